mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  CPU-side master of the data memory. Accepts one load/store request from the MEM stage and drives the
//  DMEM port (wena, in_type, addr_tail, 11-bit word addr, data_in32/16/8). For loads it returns the byte or
//  halfword lane, sign- or zero-extended. Sits between the MEM stage and DMEM. DMEM read is combinational;
//  DMEM write is on posedge clk.
// PARAMETERS
//  BASE_ADDR    32'h1001_0000  byte address mapped to DMEM word 0
//  DEPTH_WORDS  32             DMEM words implemented; indices >= this are out of range
//  DM_ADDR_W    11             DMEM word-address width
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst_n         in   1   synchronous active-low reset
//  req_valid     in   1   request offered
//  req_ready     out  1   request accepted when valid&ready
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 word, 01 half, 10 byte, 11 illegal
//  req_signed    in   1   load extension: 1 sign, 0 zero
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, low-justified
//  resp_valid    out  1   one-cycle response pulse
//  resp_rdata    out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   illegal size, out-of-range or misaligned (misaligned only with macro)
//  dm_wena       out  1   DMEM write enable
//  dm_in_type    out  2   DMEM lane size, same encoding as req_size
//  dm_addr_tail  out  2   byte offset within word
//  dm_addr       out  11  DMEM word index
//  dm_data_in32  out  32  req_wdata
//  dm_data_in16  out  16  req_wdata[15:0]
//  dm_data_in8   out  8   req_wdata[7:0]
//  dm_data_out   in   32  DMEM combinational read word
// BEHAVIOUR
//  Reset values: FSM=IDLE; all outputs 0 except req_ready=1. All dm_* fields are registered.
//  FSM IDLE->ACCESS on accept; ACCESS->RESP always; RESP->ACCESS if accept, else RESP->IDLE.
//  req_ready=1 in IDLE and RESP, 0 in ACCESS. Throughput: 1 request per 2 cycles.
//  Latency: accept at edge N; ACCESS cycle N..N+1; resp_valid=1 for exactly the cycle after edge N+1.
//  On accept, register:
//   off  = req_addr - BASE_ADDR
//   dm_addr = off[12:2]; dm_addr_tail = off[1:0]; dm_in_type = req_size; write data lanes.
//  err if req_size==11, or off[31:2] >= DEPTH_WORDS (includes req_addr < BASE_ADDR wrap).
//  dm_wena = (state==ACCESS) & we & ~err & rst_n. It is combinational-gated, so reset asserted during
//   ACCESS suppresses the write.
//  Load extract at end of ACCESS from dm_data_out:
//   byte = dout[8*tail +: 8]; half = tail[1] ? dout[31:16] : dout[15:0]; word = dout.
//   Extend per req_signed. Word ignores req_signed.
//  Store response: resp_rdata=0, resp_err=err. Errored access never writes; its rdata is 0.
//  Reset mid-operation: next state IDLE and no resp_valid. The in-flight request is dropped, with no write.
// CONFIGURATION
//  MAU_MISALIGN_CHECK_EN defined: half with off[0]=1, or word with off[1:0]!=0, sets err.
//   The store is suppressed and the load returns 0.
//  Not defined: misalignment is never an error. dm_addr_tail is forced to natural alignment:
//   word -> 00, half -> {off[1],0}.
// STRUCTURE
//  Shared package mau_pkg: SZ_WORD/SZ_HALF/SZ_BYTE/SZ_ILL encodings, state encoding, BASE_ADDR default.
//  Sub-module mau_load_align: combinational lane select and sign/zero extension (dout, size, tail, signed -> rdata).
// TESTING
//  1. sw 0xDEADBEEF @0x10010008, then lw @0x10010008
//     -> dm_wena 1 cycle with dm_addr=2, in_type=00; lw resp_rdata=0xDEADBEEF, err=0.
//  2. sb 0x80 @0x10010005, then lb and lbu @0x10010005
//     -> dm_addr=1, tail=01; lb=0xFFFFFF80, lbu=0x00000080.
//  3. sh 0x8001 @0x10010012, then lh and lhu @0x10010012
//     -> tail=10, upper half written; lh=0xFFFF8001, lhu=0x00008001.
//  4. req_addr=0x10010080 (word 32), and req_addr=0x1000FFFC
//     -> resp_err=1, dm_wena never 1, rdata=0.
//  5. Macro on: lw @0x10010002 -> err=1, rdata=0.
//     Macro off: same lw -> err=0, tail=00, data of word 0.
//  6. Back-to-back requests held valid -> accepts every 2nd cycle.
//     rst_n=0 during a store ACCESS -> no write, no resp_valid, req_ready=1 next cycle.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg
// Shared definitions for the memory access unit: access-size encodings
// (shared by the request side and the DMEM lane-size field), FSM state
// encoding, default DMEM geometry and a helper that forces a byte offset to
// natural alignment.
// Related build option: MAU_MISALIGN_CHECK_EN (see mem_access_unit.sv).
package mau_pkg;

  // Access size; the same two bits drive req_size and dm_in_type.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [31:0] MAU_BASE_ADDR   = 32'h1001_0000;
  localparam int          MAU_DEPTH_WORDS = 32;
  localparam int          MAU_DM_ADDR_W   = 11;

  // Natural alignment of a byte offset for a given size: words always start
  // at lane 0, halves at lane 0 or 2, bytes keep their lane.
  function automatic logic [1:0] natural_tail(input logic [1:0] size,
                                              input logic [1:0] off);
    logic [1:0] tail;
    tail = off;
    if (size == SZ_WORD) tail = 2'b00;
    else if (size == SZ_HALF) tail = {off[1], 1'b0};
    return tail;
  endfunction

endpackage

// File: rtl/mau_if.sv
// mau_if
// Request/response handshake between the MEM stage and the memory access unit.
// Ports (signals):
//   req_valid/req_ready  request handshake, accepted when both are high
//   req_we               1 = store, 0 = load
//   req_size             00 word, 01 half, 10 byte, 11 illegal
//   req_signed           load extension, 1 = sign, 0 = zero
//   req_addr, req_wdata  byte address and low-justified store data
//   resp_valid           one-cycle response pulse
//   resp_rdata, resp_err extended load data (0 for stores/errors) and error flag
// Modports: master = MEM stage side, slave = memory access unit side.
interface mau_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mau_load_align.sv
// mau_load_align
// Combinational load alignment: selects the byte or halfword lane of a DMEM
// read word and sign- or zero-extends it to 32 bits.
// Ports:
//   dout      in  32  DMEM read word
//   size      in  2   access size (mau_pkg size encoding)
//   tail      in  2   byte offset within the word
//   sign_ext  in  1   1 = sign-extend, 0 = zero-extend (ignored for words)
//   rdata     out 32  aligned, extended load data (0 for illegal size)
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  size,
  input  logic [1:0]  tail,
  input  logic        sign_ext,
  output logic [31:0] rdata
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  assign lane8  = dout[{tail, 3'b000} +: 8];
  // Halfword lane only depends on tail[1]; tail[0] is the misaligned bit.
  assign lane16 = tail[1] ? dout[31:16] : dout[15:0];

  always_comb begin
    rdata = '0;
    case (size)
      SZ_WORD: rdata = dout;
      SZ_HALF: rdata = {{16{sign_ext & lane16[15]}}, lane16};
      SZ_BYTE: rdata = {{24{sign_ext & lane8[7]}}, lane8};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// CPU-side master of the data memory. Accepts one load/store from the MEM
// stage, drives the DMEM port for one ACCESS cycle and returns a one-cycle
// response carrying extended load data and an error flag.
// Build option: MAU_MISALIGN_CHECK_EN - when defined, misaligned half/word
// accesses are errors; otherwise the byte offset is forced to natural
// alignment and misalignment is never an error.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   bus (slave)      request/response handshake (mau_if)
//   dm_wena          DMEM write enable, high only during ACCESS of a good store
//   dm_in_type       DMEM lane size
//   dm_addr_tail     byte offset within the word
//   dm_addr          DMEM word index
//   dm_data_in32/16/8 store data lanes
//   dm_data_out      DMEM combinational read word
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MAU_BASE_ADDR,
  parameter int          DEPTH_WORDS = MAU_DEPTH_WORDS,
  parameter int          DM_ADDR_W   = MAU_DM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mau_if.slave                 bus,
  output logic                 dm_wena,
  output logic [1:0]           dm_in_type,
  output logic [1:0]           dm_addr_tail,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [31:0]          dm_data_in32,
  output logic [15:0]          dm_data_in16,
  output logic [7:0]           dm_data_in8,
  input  logic [31:0]          dm_data_out
);

  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  state_e      state;
  logic        we_q;
  logic        err_q;
  logic        signed_q;

  logic        accept;
  logic [31:0] off;
  logic        range_err;
  logic        size_err;
  logic        misalign_err;
  logic        req_err;
  logic [1:0]  tail_next;
  logic [31:0] load_data;

  assign accept = bus.req_valid & bus.req_ready;

  // Addresses below BASE_ADDR wrap to a huge offset and so fail the range
  // check too.
  assign off       = bus.req_addr - BASE_ADDR;
  assign range_err = off[31:2] >= DEPTH_LIM;
  assign size_err  = bus.req_size == SZ_ILL;

`ifdef MAU_MISALIGN_CHECK_EN
  assign misalign_err = ((bus.req_size == SZ_HALF) & off[0]) |
                        ((bus.req_size == SZ_WORD) & (off[1:0] != 2'b00));
  assign tail_next    = off[1:0];
`else
  assign misalign_err = 1'b0;
  assign tail_next    = natural_tail(bus.req_size, off[1:0]);
`endif

  assign req_err = size_err | range_err | misalign_err;

  // Write enable is gated combinationally with rst_n so a reset landing in
  // the ACCESS cycle kills the write at the same edge.
  assign dm_wena = (state == ST_ACCESS) & we_q & ~err_q & rst_n;

  mau_load_align u_align (
    .dout     (dm_data_out),
    .size     (dm_in_type),
    .tail     (dm_addr_tail),
    .sign_ext (signed_q),
    .rdata    (load_data)
  );

  // Main FSM. IDLE and RESP both accept a new request, which gives one
  // request every two cycles; ACCESS is the single DMEM cycle, and the load
  // word is captured into the response at the end of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      signed_q       <= 1'b0;
      dm_in_type     <= '0;
      dm_addr_tail   <= '0;
      dm_addr        <= '0;
      dm_data_in32   <= '0;
      dm_data_in16   <= '0;
      dm_data_in8    <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            state         <= ST_ACCESS;
            bus.req_ready <= 1'b0;
            we_q          <= bus.req_we;
            err_q         <= req_err;
            signed_q      <= bus.req_signed;
            dm_in_type    <= bus.req_size;
            dm_addr_tail  <= tail_next;
            dm_addr       <= off[DM_ADDR_W+1:2];
            dm_data_in32  <= bus.req_wdata;
            dm_data_in16  <= bus.req_wdata[15:0];
            dm_data_in8   <= bus.req_wdata[7:0];
          end else begin
            state         <= ST_IDLE;
            bus.req_ready <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state          <= ST_RESP;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= err_q;
          bus.resp_rdata <= (we_q | err_q) ? 32'h0 : load_data;
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses and expected DMEM writes into queues; a negedge monitor pops and
// compares whenever resp_valid or dm_wena is seen. A small DMEM model sits on
// the dm_* port. Expectations depend on MAU_MISALIGN_CHECK_EN where relevant.
module tb_mem_access_unit;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    string       name;
    logic [10:0] addr;
    logic [1:0]  tail;
    logic [1:0]  typ;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        dm_wena;
  logic [1:0]  dm_in_type;
  logic [1:0]  dm_addr_tail;
  logic [10:0] dm_addr;
  logic [31:0] dm_data_in32;
  logic [15:0] dm_data_in16;
  logic [7:0]  dm_data_in8;
  logic [31:0] dm_data_out;

  logic [31:0] mem [32];

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    lat_q[$];

  int cycle;
  int assert_count;
  int fail_count;

  mau_if bus ();

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .dm_wena      (dm_wena),
    .dm_in_type   (dm_in_type),
    .dm_addr_tail (dm_addr_tail),
    .dm_addr      (dm_addr),
    .dm_data_in32 (dm_data_in32),
    .dm_data_in16 (dm_data_in16),
    .dm_data_in8  (dm_data_in8),
    .dm_data_out  (dm_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // DMEM model: combinational read, lane-masked write on posedge.
  assign dm_data_out = mem[dm_addr[4:0]];

  always @(posedge clk) begin
    if (dm_wena) begin
      case (dm_in_type)
        2'b00: mem[dm_addr[4:0]] <= dm_data_in32;
        2'b01: if (dm_addr_tail[1]) mem[dm_addr[4:0]][31:16] <= dm_data_in16;
               else mem[dm_addr[4:0]][15:0] <= dm_data_in16;
        2'b10: mem[dm_addr[4:0]][{dm_addr_tail, 3'b000} +: 8] <= dm_data_in8;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: responses, latency and DMEM writes are compared against the
  // scoreboard queues. A low rst_n drops anything in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_q.delete();
    end else begin
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          checkOutput({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
          checkOutput({e.name, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
        end
        if (lat_q.size() == 0) checkOutput("resp_without_accept", 32'd1, 32'd0);
        else checkOutput("latency", 32'(cycle - lat_q.pop_front()), 32'd2);
      end
      if (dm_wena) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_write", {21'd0, dm_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          checkOutput({w.name, "_waddr"}, {21'd0, dm_addr}, {21'd0, w.addr});
          checkOutput({w.name, "_wtail"}, {30'd0, dm_addr_tail}, {30'd0, w.tail});
          checkOutput({w.name, "_wtype"}, {30'd0, dm_in_type}, {30'd0, w.typ});
        end
      end
      if (bus.req_valid && bus.req_ready) lat_q.push_back(cycle);
    end
  end

  task automatic driveReq(input logic we, input logic [1:0] size, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sx;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic pushExp(input string name, input logic [1:0] size,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_wr, input logic [10:0] exp_waddr,
                         input logic [1:0] exp_tail);
    resp_t r;
    wr_t   w;
    r.name = name; r.rdata = exp_rdata; r.err = exp_err;
    resp_q.push_back(r);
    if (exp_wr) begin
      w.name = name; w.addr = exp_waddr; w.tail = exp_tail; w.typ = size;
      wr_q.push_back(w);
    end
  endtask

  // Issue one request (inputs change #1 after a posedge) and hold it until
  // the accepting edge.
  task automatic applyStimulus(input string name, input logic we,
                               input logic [1:0] size, input logic sx,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic exp_wr, input logic [10:0] exp_waddr,
                               input logic [1:0] exp_tail);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.req_ready) begin
      checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
    end else begin
      pushExp(name, size, exp_rdata, exp_err, exp_wr, exp_waddr, exp_tail);
      driveReq(we, size, sx, addr, wdata);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    int acc_cyc[4];
    int n;
    logic [31:0] x_rdata;
    logic        x_err;
    logic        x_wr;

    assert_count = 0;
    fail_count   = 0;
    cycle        = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    driveReq(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus.req_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("rst_dm_wena", {31'd0, dm_wena}, 32'd0);
    checkOutput("rst_dm_addr", {21'd0, dm_addr}, 32'd0);
    checkOutput("rst_dm_data32", dm_data_in32, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] word store/load");
    applyStimulus("sw_w2", 1, 2'b00, 0, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 0, 1, 11'd2, 2'b00);
    applyStimulus("lw_w2", 0, 2'b00, 1, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 0, 0, 11'd0, 2'b00);

    $display("[TB] byte store/load");
    applyStimulus("sb_w1", 1, 2'b10, 0, 32'h1001_0005, 32'hAAAA_AA80, 32'h0, 0, 1, 11'd1, 2'b01);
    applyStimulus("lb_w1", 0, 2'b10, 1, 32'h1001_0005, 32'h0, 32'hFFFF_FF80, 0, 0, 11'd0, 2'b00);
    applyStimulus("lbu_w1", 0, 2'b10, 0, 32'h1001_0005, 32'h0, 32'h0000_0080, 0, 0, 11'd0, 2'b00);

    $display("[TB] half store/load");
    applyStimulus("sh_w4", 1, 2'b01, 0, 32'h1001_0012, 32'h1234_8001, 32'h0, 0, 1, 11'd4, 2'b10);
    applyStimulus("lh_w4", 0, 2'b01, 1, 32'h1001_0012, 32'h0, 32'hFFFF_8001, 0, 0, 11'd0, 2'b00);
    applyStimulus("lhu_w4", 0, 2'b01, 0, 32'h1001_0012, 32'h0, 32'h0000_8001, 0, 0, 11'd0, 2'b00);
    applyStimulus("lh_w2lo", 0, 2'b01, 1, 32'h1001_0008, 32'h0, 32'hFFFF_BEEF, 0, 0, 11'd0, 2'b00);
    applyStimulus("lhu_w2hi", 0, 2'b01, 0, 32'h1001_000A, 32'h0, 32'h0000_DEAD, 0, 0, 11'd0, 2'b00);
    applyStimulus("lb_w2l3", 0, 2'b10, 1, 32'h1001_000B, 32'h0, 32'hFFFF_FFDE, 0, 0, 11'd0, 2'b00);
    applyStimulus("lbu_w2l0", 0, 2'b10, 0, 32'h1001_0008, 32'h0, 32'h0000_00EF, 0, 0, 11'd0, 2'b00);
    applyStimulus("lb_w4l3", 0, 2'b10, 1, 32'h1001_0013, 32'h0, 32'hFFFF_FF80, 0, 0, 11'd0, 2'b00);
    applyStimulus("lbu_w4l0", 0, 2'b10, 0, 32'h1001_0010, 32'h0, 32'h0000_0000, 0, 0, 11'd0, 2'b00);

    $display("[TB] range boundaries and illegal size");
    applyStimulus("sw_w31", 1, 2'b00, 0, 32'h1001_007C, 32'hCAFE_F00D, 32'h0, 0, 1, 11'd31, 2'b00);
    applyStimulus("lw_w31", 0, 2'b00, 0, 32'h1001_007C, 32'h0, 32'hCAFE_F00D, 0, 0, 11'd0, 2'b00);
    applyStimulus("sw_w32", 1, 2'b00, 0, 32'h1001_0080, 32'h1122_3344, 32'h0, 1, 0, 11'd0, 2'b00);
    applyStimulus("lw_w32", 0, 2'b00, 0, 32'h1001_0080, 32'h0, 32'h0, 1, 0, 11'd0, 2'b00);
    applyStimulus("sw_below", 1, 2'b00, 0, 32'h1000_FFFC, 32'h1122_3344, 32'h0, 1, 0, 11'd0, 2'b00);
    applyStimulus("lw_below", 0, 2'b00, 1, 32'h1000_FFFC, 32'h0, 32'h0, 1, 0, 11'd0, 2'b00);
    applyStimulus("ld_ill", 0, 2'b11, 1, 32'h1001_0008, 32'h0, 32'h0, 1, 0, 11'd0, 2'b00);
    applyStimulus("st_ill", 1, 2'b11, 0, 32'h1001_0008, 32'h5555_5555, 32'h0, 1, 0, 11'd0, 2'b00);
    applyStimulus("lw_w2_again", 0, 2'b00, 0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 0, 0, 11'd0, 2'b00);

    $display("[TB] misalignment");
    applyStimulus("sw_w0", 1, 2'b00, 0, 32'h1001_0000, 32'h1122_3344, 32'h0, 0, 1, 11'd0, 2'b00);
`ifdef MAU_MISALIGN_CHECK_EN
    applyStimulus("lw_mis", 0, 2'b00, 0, 32'h1001_0002, 32'h0, 32'h0, 1, 0, 11'd0, 2'b00);
    applyStimulus("lh_mis", 0, 2'b01, 1, 32'h1001_0003, 32'h0, 32'h0, 1, 0, 11'd0, 2'b00);
`else
    applyStimulus("lw_mis", 0, 2'b00, 0, 32'h1001_0002, 32'h0, 32'h1122_3344, 0, 0, 11'd0, 2'b00);
    applyStimulus("lh_mis", 0, 2'b01, 1, 32'h1001_0003, 32'h0, 32'h0000_1122, 0, 0, 11'd0, 2'b00);
`endif

    $display("[TB] back-to-back with valid held");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin pushExp("bb_lw_w2", 2'b00, 32'hDEAD_BEEF, 0, 0, 11'd0, 2'b00);
                 driveReq(0, 2'b00, 0, 32'h1001_0008, 32'h0); end
        1: begin pushExp("bb_lbu_w1", 2'b10, 32'h0000_0080, 0, 0, 11'd0, 2'b00);
                 driveReq(0, 2'b10, 0, 32'h1001_0005, 32'h0); end
        2: begin pushExp("bb_lhu_w4", 2'b01, 32'h0000_8001, 0, 0, 11'd0, 2'b00);
                 driveReq(0, 2'b01, 0, 32'h1001_0012, 32'h0); end
        default: begin pushExp("bb_lw_w0", 2'b00, 32'h1122_3344, 0, 0, 11'd0, 2'b00);
                 driveReq(0, 2'b00, 1, 32'h1001_0000, 32'h0); end
      endcase
      n = 0;
      while (!bus.req_ready && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      acc_cyc[i] = cycle;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      checkOutput("bb_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);

    $display("[TB] reset during store ACCESS");
    @(posedge clk); #1;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    driveReq(1, 2'b00, 0, 32'h1001_000C, 32'h5555_5555);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_wena", {31'd0, dm_wena}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("rst_mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_after_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    applyStimulus("lw_w3_unwritten", 0, 2'b00, 0, 32'h1001_000C, 32'h0, 32'h0, 0, 0, 11'd0, 2'b00);

    $display("[TB] misaligned word store");
`ifdef MAU_MISALIGN_CHECK_EN
    x_err = 1'b1; x_wr = 1'b0; x_rdata = 32'h0000_8000;
`else
    x_err = 1'b0; x_wr = 1'b1; x_rdata = 32'hA5A5_A5A5;
`endif
    applyStimulus("sw_mis", 1, 2'b00, 0, 32'h1001_0006, 32'hA5A5_A5A5, 32'h0, x_err, x_wr, 11'd1, 2'b00);
    applyStimulus("lw_w1", 0, 2'b00, 0, 32'h1001_0004, 32'h0, x_rdata, 0, 0, 11'd0, 2'b00);

    n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("drain_resp_q", resp_q.size(), 32'd0);
    checkOutput("drain_wr_q", wr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
